fp_adder_arbiter: RTL
=====================

FP_ADDER_ARBITER -- requirements
Module: fp_adder_arbiter

Interface
REQ-001 The block SHALL have parameter PRECISION, default 32, giving the operand and result width in bits (32 or 64).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports Load0, input, 1 bit, and Load1, input, 1 bit: one-cycle request strobes from requester 0 (FPU add/sub op) and requester 1 (divider).
REQ-005 The block SHALL have ports A0/B0 and A1/B1, input, PRECISION bits each: the operands of the corresponding request.
REQ-006 The block SHALL have ports Op0 and Op1, input, 1 bit each: 0 = add, 1 = subtract.
REQ-007 The block SHALL have ports Result0 and Result1, output, PRECISION bits each: the last adder result returned to that requester.
REQ-008 The block SHALL have ports Valid0 and Valid1, output, 1 bit each: high while that requester's Result is current; low from request acceptance until the result returns.
REQ-009 The block SHALL have ports Busy0 and Busy1, output, 1 bit each: high while that requester's request is pending or in service.
REQ-010 The block SHALL have ports AddA and AddB, output, PRECISION bits each, AddOp, output, 1 bit, and AddLoad, output, 1 bit: the request to the shared FP adder.
REQ-011 The block SHALL have ports AddValid, input, 1 bit, and AddOut, input, PRECISION bits: the adder's done flag and result.

Function
REQ-012 The block SHALL, on LoadN high with BusyN low, latch AN/BN/OpN into slot N, set BusyN and clear ValidN on the next edge.
REQ-013 The block SHALL ignore LoadN while BusyN is high, with no change to slot N, ValidN or ResultN.
REQ-014 The block SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-015 The block SHALL, in IDLE with any slot busy, grant one slot and move to ISSUE; a slot loaded in cycle t is eligible from cycle t+1.
REQ-016 The block SHALL, with exactly one slot busy, grant that slot.
REQ-017 The block SHALL, with both slots busy, grant the slot not served last; LastGrant resets to 1, so requester 0 wins the first tie.
REQ-018 The block SHALL, in ISSUE, drive AddA/AddB/AddOp from the granted slot and hold AddLoad high for exactly one cycle, then enter WAIT.
REQ-019 The block SHALL hold AddA/AddB/AddOp stable from ISSUE through the end of WAIT, and hold AddLoad low outside ISSUE.
REQ-020 The block SHALL register AddValid each cycle and detect rise = AddValid & ~AddValidQ, honouring a rise only when it is first seen after WAIT entry.
REQ-021 The block SHALL, on a rise in WAIT, write AddOut into ResultG, set ValidG, clear BusyG, update LastGrant and return to IDLE in the same edge.
REQ-022 The block SHALL ignore an AddValid rise outside WAIT.
REQ-023 The block SHALL achieve a minimum latency of LoadN to ValidN high of 3 cycles plus the adder latency, and issue the next grant no earlier than the cycle after a return.
REQ-024 The block SHALL accept a LoadN arriving in the same cycle ValidN rises as a new request on the following edge.

Reset
REQ-025 The block SHALL, on Rst high at a clock edge, enter IDLE, clear both slots, set LastGrant = 1, and drive Busy0/1, Valid0/1 and AddLoad to 0 and Result0/1, AddA, AddB and AddOp to 0.
REQ-026 The block SHALL give Rst priority over Load and AddValid.
REQ-027 The block SHALL, after Rst asserted mid-WAIT, abandon the in-flight request and never report the later adder result.

Configuration
REQ-028 The block SHALL implement round-robin arbitration per REQ-017 when macro FP_ARB_ROUND_ROBIN_EN is defined.
REQ-029 The block SHALL, without FP_ARB_ROUND_ROBIN_EN, use fixed priority on ties, with requester 1 (divider) always winning and LastGrant unused; all other behaviour is unchanged.

Verification
REQ-030 The bench SHALL cover: Load0 with A0 = 0x3FC00000 (1.5), B0 = 0x40100000 (2.25), Op0 = 0 -> one-cycle AddLoad, AddOp = 0, Result0 = 0x40700000, Valid0 rises, Valid1 stays 0.
REQ-031 The bench SHALL cover: Load1 with A1 = 0x40800000 (4.0), B1 = 0x3F800000 (1.0), Op1 = 1 -> AddOp = 1, Result1 = 0x40400000 (3.0), Busy1 falls with Valid1 rise.
REQ-032 The bench SHALL cover: Load0 and Load1 in the same cycle -> requester 0 served first with the macro defined, requester 1 first without it; exactly two AddLoad pulses.
REQ-033 The bench SHALL cover: a second Load0 with different operands during WAIT -> ignored; Result0 equals the first operation's sum.
REQ-034 The bench SHALL cover: Rst pulse during WAIT, then AddValid rises -> all outputs stay at reset values, no Valid rises.
REQ-035 The bench SHALL cover: Load0 in the cycle Valid0 rises -> accepted, Valid0 drops next edge, second AddLoad pulse issued.

Source files
------------

// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: shares one external FP adder between two requesters
// (0 = FPU add/sub, 1 = divider). Each requester owns one operand slot.
// The FSM grants one busy slot at a time, issues it to the adder and
// returns the adder result to that slot.
// Optional feature: define FP_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Without it, requester 1 always wins a tie.
//
// state | meaning
// IDLE  | nothing in flight; grant a busy slot if there is one
// ISSUE | granted operands on AddA/AddB/AddOp, AddLoad high this cycle
// WAIT  | waiting for the first AddValid rise seen after entering WAIT
module fp_adder_arbiter #(
    parameter int PRECISION = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Load0,
    input  logic                 Load1,
    input  logic [PRECISION-1:0] A0,
    input  logic [PRECISION-1:0] B0,
    input  logic [PRECISION-1:0] A1,
    input  logic [PRECISION-1:0] B1,
    input  logic                 Op0,
    input  logic                 Op1,
    output logic [PRECISION-1:0] Result0,
    output logic [PRECISION-1:0] Result1,
    output logic                 Valid0,
    output logic                 Valid1,
    output logic                 Busy0,
    output logic                 Busy1,
    output logic [PRECISION-1:0] AddA,
    output logic [PRECISION-1:0] AddB,
    output logic                 AddOp,
    output logic                 AddLoad,
    input  logic                 AddValid,
    input  logic [PRECISION-1:0] AddOut
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t               state;
    state_t               nextState;
    logic [PRECISION-1:0] slotA  [2];
    logic [PRECISION-1:0] slotB  [2];
    logic [PRECISION-1:0] result [2];
    logic [1:0]           slotOp;
    logic [1:0]           busy;
    logic [1:0]           valid;
    logic [1:0]           accept;
    logic                 grantSel;
    logic                 pick;
    logic                 tiePick;
    logic                 addValidQ;
    logic                 rise;
    logic                 done;
    logic                 granting;
    logic [PRECISION-1:0] addA;
    logic [PRECISION-1:0] addB;
    logic                 addOp;

    assign accept   = {Load1 & ~busy[1], Load0 & ~busy[0]};
    assign rise     = AddValid & ~addValidQ;
    assign done     = (state == WAIT) & rise;
    assign granting = (state == IDLE) & (|busy);

`ifdef FP_ARB_ROUND_ROBIN_EN
    logic lastGrant;

    // Remember which slot was served last; resets to 1 so slot 0 wins the first tie.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            lastGrant <= 1'b1;
        end else if (done) begin
            lastGrant <= grantSel;
        end
    end

    assign tiePick = ~lastGrant;
`else
    assign tiePick = 1'b1;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and grant selection.
    always_comb begin
        nextState = state;
        pick      = 1'b0;
        unique case (state)
            IDLE: begin
                if (|busy) begin
                    nextState = ISSUE;
                    pick      = (busy == 2'b11) ? tiePick : busy[1];
                end
            end
            ISSUE:   nextState = WAIT;
            WAIT:    if (rise) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Slots, results, adder operand hold registers and AddValid edge history.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy      <= 2'b00;
            valid     <= 2'b00;
            slotOp    <= 2'b00;
            grantSel  <= 1'b0;
            addA      <= '0;
            addB      <= '0;
            addOp     <= 1'b0;
            addValidQ <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slotA[i]  <= '0;
                slotB[i]  <= '0;
                result[i] <= '0;
            end
        end else begin
            addValidQ <= AddValid;
            if (accept[0]) begin
                slotA[0]  <= A0;
                slotB[0]  <= B0;
                slotOp[0] <= Op0;
                busy[0]   <= 1'b1;
                valid[0]  <= 1'b0;
            end
            if (accept[1]) begin
                slotA[1]  <= A1;
                slotB[1]  <= B1;
                slotOp[1] <= Op1;
                busy[1]   <= 1'b1;
                valid[1]  <= 1'b0;
            end
            // Operands are captured on the grant edge and held until the next grant.
            if (granting) begin
                grantSel <= pick;
                addA     <= slotA[pick];
                addB     <= slotB[pick];
                addOp    <= slotOp[pick];
            end
            // A granted slot is busy, so it can never be accepting in the same edge.
            if (done) begin
                result[grantSel] <= AddOut;
                valid[grantSel]  <= 1'b1;
                busy[grantSel]   <= 1'b0;
            end
        end
    end

    assign AddLoad = (state == ISSUE);
    assign AddA    = addA;
    assign AddB    = addB;
    assign AddOp   = addOp;
    assign Result0 = result[0];
    assign Result1 = result[1];
    assign Valid0  = valid[0];
    assign Valid1  = valid[1];
    assign Busy0   = busy[0];
    assign Busy1   = busy[1];

endmodule
